dmem_responder: RTL and testbench

//  Data-memory responder for the memory stage: the far end of the stage's
//  mem_read/mem_write/mem_address/mem_write_data request path. Holds a
//  64-bit-word RAM and services one request at a time over a valid/ready

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit-word data RAM serving one request at a time. Each response
// comes WAIT_STATES+1 cycles after the request is accepted. The optional alignment fault is enabled by `DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int WORD        = 64,
    parameter int DEPTH_WORDS = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A source holds valid and its payload steady until the transfer happens.
    // req_ready depends only on state. A response is held until resp_ready is seen.
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              hold_write;
    logic [WORD-1:0]   hold_addr;
    logic [WORD-1:0]   hold_wdata;
    logic [WORD-1:0]   mem [DEPTH_WORDS];

    logic              acc_write;
    logic [WORD-1:0]   acc_addr;
    logic [WORD-1:0]   acc_wdata;
    logic [AW-1:0]     acc_idx;
    logic              acc_fault;
    logic              enter_resp;
    logic              do_write;
    logic [WORD-1:0]   rdata_next;

    // With zero wait states the access commits on the accept edge itself, so it
    // uses the live request. Otherwise it uses the copy captured at accept.
    always_comb begin
        acc_write  = hold_write;
        acc_addr   = hold_addr;
        acc_wdata  = hold_wdata;
        if (state == S_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
        acc_idx   = acc_addr[3 +: AW];
        acc_fault = (acc_addr >> 3) >= WORD'(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
        if (acc_addr[2:0] != 3'b000) acc_fault = 1'b1;
`endif
        enter_resp = ((state == S_IDLE) && req_valid && req_ready && (WAIT_STATES == 0))
                   || ((state == S_WAIT) && (cnt == 4'd1));
        do_write   = enter_resp && acc_write && !acc_fault && rst_n;
        rdata_next = '0;
        if (!acc_fault && !acc_write) rdata_next = mem[acc_idx];
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[acc_idx] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        hold_write <= req_write;
                        hold_addr  <= req_addr;
                        hold_wdata <= req_wdata;
                        req_ready  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rdata_next;
                            resp_err   <= acc_fault;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (enter_resp) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_next;
                        resp_err   <= acc_fault;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: random loads/stores against an array model,
// plus directed reset, back-pressure, range, alignment and zero-wait cases.
module tb_dmem_responder;
    localparam int DEPTH = 32;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [1:0]  dbg_state;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b0;
    logic [63:0] z_req_addr = '0, z_req_wdata = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [63:0] z_resp_rdata;
    logic [1:0]  z_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.WORD(64), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    dmem_responder #(.WORD(64), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .dbg_state(z_dbg_state)
    );

    // Reference: word-addressed array, fault on out-of-range (or misaligned).
    function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d,
                                  output logic [63:0] rd, output logic er);
        logic [63:0] wi;
        wi = a / 8;
        er = (wi >= 64'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((a % 8) != 0) er = 1'b1;
`endif
        rd = '0;
        if (!er) begin
            if (w) ref_mem[wi] = d;
            else   rd = ref_mem[wi];
        end
    endfunction

    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
        int guard;
        rd = '0; er = 1'b0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout resp_valid=%b required 1", resp_valid);
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_zw ready=%b valid=%b required 1 0", z_req_ready, z_resp_valid);
        end
    endtask

    task automatic test_init_mem();
        logic [63:0] rd, erd, d;
        logic er, eer;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            model(1'b1, 64'(i * 8), d, erd, eer);
            do_req(1'b1, 64'(i * 8), d, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat !== WS + 1) begin
                errors++;
                $display("FAIL init_store[%0d] rdata=%h err=%b lat=%0d required %h %b %0d",
                         i, rd, er, lat, erd, eer, WS + 1);
            end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        model(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, erd, eer);
        do_req(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, rd, er, lat);
        checks++;
        if (rd !== 64'd0 || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL store_0x10 rdata=%h err=%b lat=%0d required 0 0 3", rd, er, lat);
        end
        model(1'b0, 64'h10, 64'd0, erd, eer);
        do_req(1'b0, 64'h10, 64'd0, rd, er, lat);
        checks++;
        if (rd !== 64'hDEAD_BEEF_0000_0001 || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL load_0x10 rdata=%h err=%b lat=%0d required deadbeef00000001 0 3", rd, er, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, a2, d2, erd1, erd2, rd;
        logic eer1, eer2, er;
        int lat;
        a1 = 64'($urandom_range(0, DEPTH - 1) * 8);
        a2 = 64'($urandom_range(0, DEPTH - 1) * 8);
        d2 = {$urandom, $urandom};
        model(1'b0, a1, 64'd0, erd1, eer1);
        model(1'b1, a2, d2, erd2, eer2);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle_ready req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a1; resp_ready = 1'b0;
        @(negedge clk);
        // Next request presented immediately and held: must not be lost.
        req_write = 1'b1; req_addr = a2; req_wdata = d2;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== WS + 1) begin
            errors++;
            $display("FAIL bp_latency lat=%0d required %0d", lat, WS + 1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== erd1 || resp_err !== eer1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, erd1, eer1);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL bp_release valid=%b ready=%b rdata=%h required 0 1 0", resp_valid, req_ready, resp_rdata);
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        checks++;
        if (rd !== erd2 || er !== eer2 || lat !== WS + 1) begin
            errors++;
            $display("FAIL bp_held_req rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, erd2, eer2, WS + 1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_range();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        do_req(1'b0, 64'h100, 64'd0, rd, er, lat);
        checks++;
        if (rd !== 64'd0 || er !== 1'b1 || lat !== WS + 1) begin
            errors++;
            $display("FAIL range_load rdata=%h err=%b lat=%0d required 0 1 %0d", rd, er, lat, WS + 1);
        end
        do_req(1'b1, 64'h100, 64'hFFFF_0000_FFFF_0000, rd, er, lat);
        checks++;
        if (rd !== 64'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL range_store rdata=%h err=%b required 0 1", rd, er);
        end
        do_req(1'b1, 64'h8000_0000_0000_0000, 64'h1, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL range_high err=%b required 1", er);
        end
        model(1'b0, 64'h0, 64'd0, erd, eer);
        do_req(1'b0, 64'h0, 64'd0, rd, er, lat);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL range_word0 rdata=%h err=%b required %h 0", rd, er, erd);
        end
    endtask

    task automatic test_align();
        logic [63:0] rd, erd;
        logic er, eer, req_err;
        int lat;
`ifdef DMEM_ALIGN_CHECK_EN
        req_err = 1'b1;
`else
        req_err = 1'b0;
`endif
        model(1'b1, 64'h0B, 64'h1234, erd, eer);
        do_req(1'b1, 64'h0B, 64'h1234, rd, er, lat);
        checks++;
        if (er !== req_err || rd !== 64'd0 || lat !== WS + 1) begin
            errors++;
            $display("FAIL align_store err=%b rdata=%h lat=%0d required %b 0 %0d", er, rd, lat, req_err, WS + 1);
        end
        model(1'b0, 64'h08, 64'd0, erd, eer);
        do_req(1'b0, 64'h08, 64'd0, rd, er, lat);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL align_readback rdata=%h err=%b required %h 0", rd, er, erd);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, d, rd, erd, exp_rd;
        logic w, er, eer;
        int lat;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 64'($urandom_range(0, 287));
            d = {$urandom, $urandom};
            model(w, a, d, erd, eer);
            exp_q.push_back(erd);
            do_req(w, a, d, rd, er, lat);
            exp_rd = exp_q.pop_front();
            checks++;
            if (rd !== exp_rd || er !== eer || lat !== WS + 1) begin
                errors++;
                $display("FAIL random[%0d] w=%b a=%h rdata=%h err=%b lat=%0d required %h %b %0d",
                         n, w, a, rd, er, lat, exp_rd, eer, WS + 1);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_wait ready=%b valid=%b err=%b rdata=%h required 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst_n = 1'b1;
        model(1'b0, 64'h18, 64'd0, erd, eer);
        do_req(1'b0, 64'h18, 64'd0, rd, er, lat);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped_write rdata=%h err=%b required %h 0", rd, er, erd);
        end
    endtask

    task automatic test_zero_wait();
        logic [63:0] r0 [4];
        logic [63:0] zq[$];
        logic [63:0] exp_rd;
        logic acc;
        int idx, nresp, cycles;
        for (int i = 0; i < 4; i++) r0[i] = {$urandom, $urandom};
        idx = 0; nresp = 0; cycles = 0;
        @(negedge clk);
        z_resp_ready = 1'b1;
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 64'h0; z_req_wdata = r0[0];
        for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
            acc = z_req_ready;
            if (acc) zq.push_back(z_req_write ? 64'd0 : r0[z_req_addr[4:3]]);
            @(negedge clk);
            cycles++;
            checks++;
            if (z_resp_valid !== acc) begin
                errors++;
                $display("FAIL zw_timing cyc=%0d resp_valid=%b required %b", cyc, z_resp_valid, acc);
            end
            if (z_resp_valid === 1'b1 && zq.size() > 0) begin
                exp_rd = zq.pop_front();
                nresp++;
                checks++;
                if (z_resp_rdata !== exp_rd || z_resp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL zw_data[%0d] rdata=%h err=%b required %h 0", nresp, z_resp_rdata, z_resp_err, exp_rd);
                end
            end
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    z_req_write = (idx < 4);
                    z_req_addr  = 64'((idx % 4) * 8);
                    z_req_wdata = (idx < 4) ? r0[idx] : 64'({$urandom, $urandom});
                end else begin
                    z_req_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (nresp !== 8 || cycles !== 15) begin
            errors++;
            $display("FAIL zw_throughput responses=%0d cycles=%0d required 8 15", nresp, cycles);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_init_mem();
        test_store_load();
        test_backpressure();
        test_range();
        test_align();
        test_random();
        test_reset_mid_wait();
        test_zero_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
